// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: decodes opcode/opext, latches operands and
// executes single-cycle ops, iterative MUL and bit-serial shifts.
module alu_op_sequencer #(
   parameter int WIDTH = 16,
   parameter int CW    = 4,
   parameter int SW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [3:0]       opext,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [CW-1:0]    alucont,
   output logic             illegal
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [CW-1:0] C_ADD  = CW'(0);
   localparam logic [CW-1:0] C_SUB  = CW'(1);
   localparam logic [CW-1:0] C_AND  = CW'(2);
   localparam logic [CW-1:0] C_XOR  = CW'(3);
   localparam logic [CW-1:0] C_OR   = CW'(4);
   localparam logic [CW-1:0] C_MUL  = CW'(5);
   localparam logic [CW-1:0] C_LSH  = CW'(6);
   localparam logic [CW-1:0] C_ASHU = CW'(7);
   localparam logic [CW-1:0] C_ILL  = {CW{1'b1}};

   state_t           state, state_nx;
   logic [CW-1:0]    code_d;
   logic [WIDTH-1:0] alu_d;
   logic [SW-1:0]    amt, mag;
   logic             accept, is_mul, is_shift;
   logic [WIDTH-1:0] opa, opb;
   logic [SW-1:0]    cnt;
   logic             neg;

   // R-type extensions and immediate opcodes share one encoding map
   function automatic logic [CW-1:0] op_map(input logic [3:0] f);
      case (f)
         4'b0101: op_map = C_ADD;
         4'b1001: op_map = C_SUB;
         4'b0001: op_map = C_AND;
         4'b0011: op_map = C_XOR;
         4'b0010: op_map = C_OR;
         4'b1110: op_map = C_MUL;
         default: op_map = C_ILL;
      endcase
   endfunction

   always_comb begin
      code_d = C_ILL;
      if (opcode == 4'b0000) begin
         code_d = op_map(opext);
      end else if (opcode == 4'b1000) begin
         if (opext == 4'b0100)
            code_d = C_LSH;
         else if (opext == 4'b0110)
            code_d = C_ASHU;
      end else begin
         code_d = op_map(opcode);
      end
      amt = b[SW-1:0];
      mag = amt[SW-1] ? (~amt + SW'(1)) : amt;
      case (code_d)
         C_ADD:   alu_d = a + b;
         C_SUB:   alu_d = a - b;
         C_AND:   alu_d = a & b;
         C_XOR:   alu_d = a ^ b;
         C_OR:    alu_d = a | b;
         default: alu_d = '0;
      endcase
   end

   always_comb begin
      state_nx  = state;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      accept    = in_valid && in_ready;
      is_mul    = (code_d == C_MUL);
      is_shift  = (code_d == C_LSH) || (code_d == C_ASHU);
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (is_mul || (is_shift && mag != '0))
                  state_nx = EXEC;
               else
                  state_nx = DONE;
            end
         end
         EXEC: begin
            if (cnt == SW'(1))
               state_nx = DONE;
         end
         DONE: begin
            if (out_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result  <= '0;
         alucont <= '0;
         illegal <= 1'b0;
         opa     <= '0;
         opb     <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
      end else if (state == IDLE && accept) begin
         alucont <= code_d;
         illegal <= (code_d == C_ILL);
         opa     <= a;
         opb     <= b;
         neg     <= amt[SW-1];
         if (is_mul) begin
            result <= '0;
            cnt    <= SW'(WIDTH);
         end else if (is_shift) begin
            result <= a;
            cnt    <= mag;
         end else begin
            result <= alu_d;
            cnt    <= '0;
         end
      end else if (state == EXEC) begin
         cnt <= cnt - SW'(1);
         // MUL: shift-add over multiplier bits, LSB first
         if (alucont == C_MUL) begin
            if (opb[0])
               result <= result + opa;
            opa <= opa << 1;
            opb <= opb >> 1;
         end else if (neg) begin
            result <= {(alucont == C_ASHU) & result[WIDTH-1],
                       result[WIDTH-1:1]};
         end else begin
            result <= result << 1;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed ops pushed as expected
// responses, a negedge monitor pops and compares each output transfer.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [3:0]  opext;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  alucont;
   logic        illegal;

   alu_op_sequencer #(.WIDTH(16), .CW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .opext     (opext),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .alucont   (alucont),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] res;
      logic [3:0]  code;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got result %h expected none",
                     result);
         end else begin
            me = q.pop_front();
            chk({me.name, "_result"}, 32'(result), 32'(me.res));
            chk({me.name, "_alucont"}, 32'(alucont), 32'(me.code));
            chk({me.name, "_illegal"}, 32'(illegal), 32'(me.ill));
            chk({me.name, "_latency"}, 32'(cyc - me.acc + 1), 32'(me.lat));
         end
      end
   end

   // called at posedge+2; returns at posedge+2 just after the accept edge
   task automatic issue(input string nm, input logic [3:0] op,
                        input logic [3:0] ext, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] er,
                        input logic [3:0] ec, input logic ei, input int lat);
      int g;
      g = 0;
      while (!in_ready && g < 100) begin
         @(posedge clk);
         #2;
         g++;
      end
      opcode   = op;
      opext    = ext;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      q.push_back('{name: nm, res: er, code: ec, ill: ei, lat: lat,
                    acc: cyc + 1});
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int   g;
      logic busy_hi;
      g = 0;
      busy_hi = 1'b0;
      while (q.size() != 0 && g < 60) begin
         if (in_ready)
            busy_hi = 1'b1;
         @(posedge clk);
         #2;
         g++;
      end
      chk({nm, "_drain"}, 32'(q.size()), 32'd0);
      chk({nm, "_busy_ready"}, 32'(busy_hi), 32'd0);
      q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      opcode    = '0;
      opext     = '0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_alucont", 32'(alucont), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      issue("add", 4'b0000, 4'b0101, 16'h7FFF, 16'h0001,
            16'h8000, 4'h0, 1'b0, 1);
      wait_done("add");
      issue("sub", 4'b0000, 4'b1001, 16'h0000, 16'h0001,
            16'hFFFF, 4'h1, 1'b0, 1);
      wait_done("sub");
      issue("and", 4'b0000, 4'b0001, 16'h0F0F, 16'h00FF,
            16'h000F, 4'h2, 1'b0, 1);
      wait_done("and");
      issue("xor", 4'b0000, 4'b0011, 16'hFF00, 16'h0FF0,
            16'hF0F0, 4'h3, 1'b0, 1);
      wait_done("xor");
      issue("addi", 4'b0101, 4'b1111, 16'h0003, 16'h0004,
            16'h0007, 4'h0, 1'b0, 1);
      wait_done("addi");
      issue("ori", 4'b0010, 4'b0000, 16'h00F0, 16'h000F,
            16'h00FF, 4'h4, 1'b0, 1);
      wait_done("ori");

      issue("mul", 4'b0000, 4'b1110, 16'h0003, 16'h0005,
            16'h000F, 4'h5, 1'b0, 17);
      wait_done("mul");
      issue("muli", 4'b1110, 4'b0000, 16'hFFFF, 16'hFFFF,
            16'h0001, 4'h5, 1'b0, 17);
      wait_done("muli");

      issue("lsh_l4", 4'b1000, 4'b0100, 16'h0001, 16'h0004,
            16'h0010, 4'h6, 1'b0, 5);
      wait_done("lsh_l4");
      issue("lsh_r4", 4'b1000, 4'b0100, 16'h8000, 16'h001C,
            16'h0800, 4'h6, 1'b0, 5);
      wait_done("lsh_r4");
      issue("ashu_r4", 4'b1000, 4'b0110, 16'h8000, 16'h001C,
            16'hF800, 4'h7, 1'b0, 5);
      wait_done("ashu_r4");
      issue("lsh_z", 4'b1000, 4'b0100, 16'h1234, 16'h0000,
            16'h1234, 4'h6, 1'b0, 1);
      wait_done("lsh_z");
      issue("ashu_r16", 4'b1000, 4'b0110, 16'h8000, 16'h0010,
            16'hFFFF, 4'h7, 1'b0, 17);
      wait_done("ashu_r16");
      issue("lsh_r16", 4'b1000, 4'b0100, 16'h1234, 16'h0010,
            16'h0000, 4'h6, 1'b0, 17);
      wait_done("lsh_r16");
      issue("ill_ext", 4'b1000, 4'b0000, 16'h1111, 16'h2222,
            16'h0000, 4'hF, 1'b1, 1);
      wait_done("ill_ext");

      out_ready = 1'b0;
      issue("ill_bp", 4'b1111, 4'b0000, 16'h1234, 16'h5678,
            16'h0000, 4'hF, 1'b1, 4);
      opcode   = 4'b0101;
      a        = 16'h0001;
      b        = 16'h0001;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_result", 32'(result), 32'd0);
         chk("bp_alucont", 32'(alucont), 32'hF);
         @(posedge clk);
         #2;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
      chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
      wait_done("ill_bp");
      repeat (3) @(posedge clk);
      #2;

      issue("mul_rst", 4'b0000, 4'b1110, 16'h0003, 16'h0005,
            16'h000F, 4'h5, 1'b0, 17);
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_result", 32'(result), 32'd0);
      chk("mrst_alucont", 32'(alucont), 32'd0);
      q.delete();
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      issue("add_post", 4'b0000, 4'b0101, 16'h0002, 16'h0002,
            16'h0004, 4'h0, 1'b0, 1);
      wait_done("add_post");

      repeat (5) @(posedge clk);
      #2;
      chk("final_queue", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
